regfile_port_arbiter: RTL and testbench
=======================================

Name: regfile_port_arbiter

Overview:
- Shares one 32-entry register file (1 write port, 2 registered read ports) among NUM_REQ requesters.
- Each cycle it grants at most 1 write and 2 reads, using a round-robin scan.
- It never presents an address pattern that sets the register file's sticky collision flag, and it routes read data back to the owning requester.
- Sits between requesters and the register file; drives all of the register file's write, read and enable inputs.

Parameters:
- DATA_WIDTH, 16, register word width.
- NUM_REQ, 4, number of requesters (2..8).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  request pending per requester.
- req_we  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*5  register address; requester i uses bits [5i+4:5i].
- req_wdata  in  NUM_REQ*DATA_WIDTH  write data per requester.
- req_ready  out  NUM_REQ  grant; transfer happens when valid & ready.
- rsp_valid  out  NUM_REQ  read data valid for requester i.
- rsp_data  out  NUM_REQ*DATA_WIDTH  read data per requester.
- rf_din  out  DATA_WIDTH  register file write data.
- rf_wad  out  5  register file write address.
- rf_wen  out  1  register file write enable.
- rf_rad1, rf_rad2  out  5 each  register file read addresses.
- rf_ren1, rf_ren2  out  1 each  register file read enables.
- rf_dout1, rf_dout2  in  DATA_WIDTH each  register file read data (valid 1 cycle after ren).
- rf_collision  in  1  register file collision flag (sticky).
- err  out  1  arbiter in ERR state.
- err_clr  in  1  leave ERR state.

Behaviour:
- Reset values: state RUN, rr_ptr 0, req_ready 0, rsp_valid 0, rsp_data 0, err 0, rf_wen/ren1/ren2 0, owner registers invalid.
- Clock/reset: one clock, clk; reset is synchronous, active-high, named reset. A reset mid-operation drops outstanding read responses; rsp_valid is 0 on the following cycle.
- Handshake:
  - req_ready is combinational from the current-cycle requests and state.
  - A requester holds valid, we, addr and wdata stable until ready. A request may be withdrawn only when ready is low.
- Arbitration in RUN, scanning in order rr_ptr, rr_ptr+1, … mod NUM_REQ:
  - Write pass: first valid writer wins. Drives rf_wen=1, rf_wad=addr, rf_din=wdata.
  - Read pass: first valid reader goes to port 1 and the next to port 2.
  - A reader is skipped if its addr equals the granted write addr or the port-1 addr. Skipped readers keep ready low and retry later.
  - The write always wins over a same-address read in the same cycle. The read is deferred one or more cycles and then returns the new data.
- Idle read port: when rf_ren1 or rf_ren2 is 0, the matching rf_rad is driven to ~rf_wad. An unused address therefore never matches an active write.
- Pointer update: when any grant occurs, rr_ptr becomes (index of first granted requester in scan order + 1) mod NUM_REQ. With no grant, rr_ptr holds.
- Read response latency is 1:
  - Owner registers (p1_owner, p1_vld, p2_owner, p2_vld) capture the requester index per port at grant.
  - Next cycle, rsp_valid[owner]=1 and rsp_data[owner] = rf_dout1 or rf_dout2.
  - rsp_data for non-valid requesters reads 0. A requester can never receive two responses in one cycle.
- Back-to-back: a requester may be granted every cycle. Throughput is 1 write + 2 reads per cycle.
- ERR state:
  - Entered on the cycle after rf_collision=1 is sampled. rf_collision is an internal-bug indicator.
  - In ERR: all req_ready=0, all rf enables=0, err=1. Responses already in flight still complete.
  - err_clr=1 with rf_collision=0 returns to RUN next cycle. err_clr is ignored in RUN.
  - rf_collision is sticky, so clearing it needs the register file reset.
- Boundary conditions:
  - All requesters writing: exactly one is granted per cycle, rotating.
  - All requesters reading the same addr: one is granted per cycle.
  - NUM_REQ=2: both reads may be granted together.

Decomposition:
- Package regfile_arb_pkg:
  - RF_ADDR_W=5, RF_DEPTH=32.
  - State enum {RUN, ERR}.
  - Function clog2 for index width.
- One sub-module, rr_pick: given a request mask, pointer and exclude mask, returns found plus the first index at or after the pointer.
  - Instantiated three times: write winner, read port 1, read port 2.

Test Plan:
- Reset, then req0 read addr 5 (never written) -> ready0 the same cycle; next cycle rsp_valid[0]=1, rsp_data0=0x0000.
- req1 write addr 5 data 0xBEEF while req2 reads addr 5 in the same cycle -> write granted, req2 deferred; on retry req2 gets 0xBEEF; rf_collision stays 0.
- req0 and req3 both read addr 9 -> only one granted per cycle, ready order follows rr_ptr; both eventually get the same data; collision stays 0.
- All 4 requesters issue writes continuously -> grants rotate 0,1,2,3,0…; no requester waits more than 3 cycles.
- Write addr 2 plus reads of addr 7 and 12 from three requesters in one cycle -> all three granted that cycle; rad1=7, rad2=12; responses land on the correct requesters.
- Force rf_collision=1 -> err=1 next cycle, all ready=0; release rf_collision and pulse err_clr -> RUN; assert reset mid-read -> rsp_valid=0 the next cycle.

Source files
------------

// File: rtl/regfile_arb_pkg.sv
// Shared definitions for the register-file port arbiter.
//   RF_ADDR_W / RF_DEPTH : register file geometry (32 x DATA_WIDTH)
//   arb_state_t          : arbiter mode, RUN (granting) or ERR (frozen)
//   clog2                : index width helper, never returns less than 1
package regfile_arb_pkg;

  localparam int RF_ADDR_W = 5;
  localparam int RF_DEPTH  = 32;

  typedef enum logic {
    RUN = 1'b0,
    ERR = 1'b1
  } arb_state_t;

  // Bounded loop keeps this usable as a constant function for parameter widths.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/regfile_port_arbiter_rr_pick.sv
// Round-robin picker.
//   req   : candidate mask
//   ptr   : scan start index
//   excl  : candidates to ignore this cycle
//   found : at least one eligible candidate exists
//   idx   : first eligible candidate at or after ptr (wrapping), 0 if none
module rr_pick
  import regfile_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic [N-1:0]  excl,
  output logic          found,
  output logic [IW-1:0] idx
);

  // Walk the candidates in scan order and latch the first eligible one.
  always_comb begin
    int            pos;
    logic [IW-1:0] pos_idx;
    found   = 1'b0;
    idx     = '0;
    pos     = 0;
    pos_idx = '0;
    for (int k = 0; k < N; k++) begin
      pos     = (int'(ptr) + k) % N;
      pos_idx = IW'(pos);
      if (!found && req[pos_idx] && !excl[pos_idx]) begin
        found = 1'b1;
        idx   = pos_idx;
      end
    end
  end

endmodule

// File: rtl/regfile_port_arbiter.sv
// Arbiter sharing one 32-entry register file (1 write port, 2 registered
// read ports) among NUM_REQ requesters.
//   clk, reset                 : clock, synchronous active-high reset
//   req_valid/we/addr/wdata    : per-requester request bundle
//   req_ready                  : per-requester grant (combinational)
//   rsp_valid/rsp_data         : read response, one cycle after grant
//   rf_din/wad/wen             : register file write port
//   rf_rad1/2, rf_ren1/2       : register file read ports
//   rf_dout1/2                 : register file read data (1-cycle latency)
//   rf_collision               : sticky register file collision flag
//   err, err_clr               : error indication and its clear
module regfile_port_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REQ    = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0]              req_we,
  input  logic [NUM_REQ*RF_ADDR_W-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [NUM_REQ*DATA_WIDTH-1:0]   rsp_data,
  output logic [DATA_WIDTH-1:0]           rf_din,
  output logic [RF_ADDR_W-1:0]            rf_wad,
  output logic                            rf_wen,
  output logic [RF_ADDR_W-1:0]            rf_rad1,
  output logic [RF_ADDR_W-1:0]            rf_rad2,
  output logic                            rf_ren1,
  output logic                            rf_ren2,
  input  logic [DATA_WIDTH-1:0]           rf_dout1,
  input  logic [DATA_WIDTH-1:0]           rf_dout2,
  input  logic                            rf_collision,
  output logic                            err,
  input  logic                            err_clr
);

  localparam int IW = clog2(NUM_REQ);

  arb_state_t state, state_next;

  logic [IW-1:0] rr_ptr, rr_ptr_next;
  logic [IW-1:0] p1_owner, p2_owner;
  logic          p1_vld, p2_vld;

  logic [RF_ADDR_W-1:0]  addr_of  [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_of [NUM_REQ];

  logic [NUM_REQ-1:0] wr_req, rd_req, no_excl, rd_excl1, rd_excl2;
  logic               w_found, p1_found, p2_found;
  logic [IW-1:0]      w_idx, p1_idx, p2_idx;
  logic [RF_ADDR_W-1:0] w_addr, p1_addr;
  logic               grant_en, grant_w, grant_1, grant_2;

  // Split the flat request buses into per-requester views.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_of[i]  = req_addr[i*RF_ADDR_W +: RF_ADDR_W];
      wdata_of[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign wr_req  = req_valid & req_we;
  assign rd_req  = req_valid & ~req_we;
  assign no_excl = '0;

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick_wr (
    .req  (wr_req),
    .ptr  (rr_ptr),
    .excl (no_excl),
    .found(w_found),
    .idx  (w_idx)
  );

  assign w_addr = addr_of[w_idx];

  // Readers that hit the granted write address are held off so the register
  // file never sees a read and write of one address together; the second
  // port additionally avoids the first port's address. Excluding by address
  // also removes the port-1 winner itself from the port-2 scan.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      rd_excl1[i] = w_found && (addr_of[i] == w_addr);
      rd_excl2[i] = rd_excl1[i] || (p1_found && (addr_of[i] == p1_addr));
    end
  end

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick_rd1 (
    .req  (rd_req),
    .ptr  (rr_ptr),
    .excl (rd_excl1),
    .found(p1_found),
    .idx  (p1_idx)
  );

  assign p1_addr = addr_of[p1_idx];

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick_rd2 (
    .req  (rd_req),
    .ptr  (rr_ptr),
    .excl (rd_excl2),
    .found(p2_found),
    .idx  (p2_idx)
  );

  // Grants are suppressed while in ERR and during reset.
  assign grant_en = (state == RUN) && !reset;
  assign grant_w  = grant_en && w_found;
  assign grant_1  = grant_en && p1_found;
  assign grant_2  = grant_en && p2_found;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_next;
  end

  // Next-state logic: a sampled collision freezes the arbiter; leaving ERR
  // needs err_clr while the collision flag is already clear.
  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (rf_collision) state_next = ERR;
      ERR:     if (err_clr && !rf_collision) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // Output logic: grants, register file controls, response routing.
  // Idle read addresses are the inverse of the write address so they can
  // never alias an active write.
  always_comb begin
    logic [RF_ADDR_W-1:0] wad;
    req_ready = '0;
    rsp_valid = '0;
    rsp_data  = '0;
    err       = (state == ERR);
    wad       = grant_w ? w_addr : '0;
    rf_wen    = grant_w;
    rf_wad    = wad;
    rf_din    = grant_w ? wdata_of[w_idx] : '0;
    rf_ren1   = grant_1;
    rf_rad1   = grant_1 ? p1_addr : ~wad;
    rf_ren2   = grant_2;
    rf_rad2   = grant_2 ? addr_of[p2_idx] : ~wad;
    if (grant_w) req_ready[w_idx]  = 1'b1;
    if (grant_1) req_ready[p1_idx] = 1'b1;
    if (grant_2) req_ready[p2_idx] = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (p1_vld && (p1_owner == IW'(i))) begin
        rsp_valid[i]                        = 1'b1;
        rsp_data[i*DATA_WIDTH +: DATA_WIDTH] = rf_dout1;
      end
      if (p2_vld && (p2_owner == IW'(i))) begin
        rsp_valid[i]                        = 1'b1;
        rsp_data[i*DATA_WIDTH +: DATA_WIDTH] = rf_dout2;
      end
    end
  end

  // Pointer moves just past the earliest grant in scan order, so that
  // requester gets lowest priority next cycle.
  always_comb begin
    int            pos;
    logic [IW-1:0] pos_idx;
    logic          hit;
    rr_ptr_next = rr_ptr;
    hit         = 1'b0;
    pos         = 0;
    pos_idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos     = (int'(rr_ptr) + k) % NUM_REQ;
      pos_idx = IW'(pos);
      if (!hit && req_ready[pos_idx]) begin
        hit         = 1'b1;
        rr_ptr_next = IW'((pos + 1) % NUM_REQ);
      end
    end
  end

  // Pointer and per-port owner tracking for the one-cycle read latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr   <= '0;
      p1_owner <= '0;
      p2_owner <= '0;
      p1_vld   <= 1'b0;
      p2_vld   <= 1'b0;
    end else begin
      rr_ptr   <= rr_ptr_next;
      p1_owner <= p1_idx;
      p2_owner <= p2_idx;
      p1_vld   <= grant_1;
      p2_vld   <= grant_2;
    end
  end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Self-checking bench for regfile_port_arbiter with a behavioural register
// file (sticky collision flag) and a scan-order reference arbiter.
module tb_regfile_port_arbiter;

  localparam int N  = 4;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid, req_we, req_ready, rsp_valid;
  logic [N*5-1:0]  req_addr;
  logic [N*DW-1:0] req_wdata, rsp_data;
  logic [DW-1:0]   rf_din, rf_dout1, rf_dout2;
  logic [4:0]      rf_wad, rf_rad1, rf_rad2;
  logic            rf_wen, rf_ren1, rf_ren2, rf_collision, err, err_clr;

  logic            rf_clear, coll_flag, force_coll;
  logic [DW-1:0]   rf_mem [32];

  int checks = 0;
  int errors = 0;

  regfile_port_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(N)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rf_din(rf_din), .rf_wad(rf_wad), .rf_wen(rf_wen),
    .rf_rad1(rf_rad1), .rf_rad2(rf_rad2), .rf_ren1(rf_ren1), .rf_ren2(rf_ren2),
    .rf_dout1(rf_dout1), .rf_dout2(rf_dout2),
    .rf_collision(rf_collision), .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // Register file model: registered reads, sticky flag when an active write
  // address appears on either read address.
  assign rf_collision = coll_flag | force_coll;

  always @(posedge clk) begin
    if (rf_clear) begin
      for (int j = 0; j < 32; j++) rf_mem[j] <= '0;
      coll_flag <= 1'b0;
      rf_dout1  <= '0;
      rf_dout2  <= '0;
    end else begin
      if (rf_ren1) rf_dout1 <= rf_mem[rf_rad1];
      if (rf_ren2) rf_dout2 <= rf_mem[rf_rad2];
      if (rf_wen) rf_mem[rf_wad] <= rf_din;
      if (rf_wen && (rf_rad1 == rf_wad || rf_rad2 == rf_wad)) coll_flag <= 1'b1;
    end
  end

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  we;
    logic [19:0] addr;
    logic [3:0]  exp_ready;
    logic [17:0] exp_rf;
  } vec_t;

  vec_t vecs [6];

  task automatic applyStimulus(input logic [3:0] v, input logic [3:0] we,
                               input logic [19:0] a, input logic [63:0] wd);
    req_valid = v;
    req_we    = we;
    req_addr  = a;
    req_wdata = wd;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic doReset(input logic clear_rf);
    reset    = 1'b1;
    rf_clear = clear_rf;
    applyStimulus('0, '0, '0, '0);
    @(posedge clk);
    @(negedge clk);
    reset    = 1'b0;
    rf_clear = 1'b0;
  endtask

  // Reference arbiter: builds the scan order list and applies the grant
  // rules directly (one writer, up to two readers on distinct addresses
  // that differ from the written address).
  function automatic logic [3:0] ref_grant(input logic [3:0] v, input logic [3:0] we,
                                           input logic [19:0] a, input int ptr,
                                           output int nptr);
    int         order [N];
    logic [4:0] ad [N];
    int         wi, r1, r2, i;
    logic [3:0] g;
    wi = -1; r1 = -1; r2 = -1; g = '0;
    for (int k = 0; k < N; k++) begin
      ad[k]    = a[5*k +: 5];
      order[k] = (ptr + k) % N;
    end
    for (int k = 0; k < N; k++) begin
      i = order[k];
      if (v[i] && we[i] && wi < 0) wi = i;
    end
    for (int k = 0; k < N; k++) begin
      i = order[k];
      if (v[i] && !we[i] && !(wi >= 0 && ad[i] == ad[wi])) begin
        if (r1 < 0) r1 = i;
        else if (r2 < 0 && ad[i] != ad[r1]) r2 = i;
      end
    end
    if (wi >= 0) g[wi] = 1'b1;
    if (r1 >= 0) g[r1] = 1'b1;
    if (r2 >= 0) g[r2] = 1'b1;
    nptr = ptr;
    for (int k = 0; k < N; k++) begin
      if (g[order[k]]) begin
        nptr = (order[k] + 1) % N;
        break;
      end
    end
    return g;
  endfunction

  logic [3:0]  pv, pwe, g, exp_rv;
  logic [19:0] pa;
  logic [63:0] pwd, exp_rd;
  logic [15:0] mmem [32];
  int          mptr, nptr;
  logic [17:0] act_rf;

  initial begin
    // {wen, wad, ren1, rad1, ren2, rad2}; addresses of idle ports are zeroed
    vecs[0] = '{4'b1011, 4'b0001, {5'd12, 5'd0, 5'd7, 5'd2}, 4'b1011, {1'b1, 5'd2, 1'b1, 5'd7, 1'b1, 5'd12}};
    vecs[1] = '{4'b1111, 4'b0000, {5'd9, 5'd9, 5'd9, 5'd9},  4'b0001, {1'b0, 5'd0, 1'b1, 5'd9, 1'b0, 5'd0}};
    vecs[2] = '{4'b1111, 4'b1111, {5'd4, 5'd3, 5'd2, 5'd1},  4'b0001, {1'b1, 5'd1, 1'b0, 5'd0, 1'b0, 5'd0}};
    vecs[3] = '{4'b0111, 4'b0010, {5'd0, 5'd6, 5'd5, 5'd5},  4'b0110, {1'b1, 5'd5, 1'b1, 5'd6, 1'b0, 5'd0}};
    vecs[4] = '{4'b0111, 4'b0000, {5'd0, 5'd4, 5'd3, 5'd3},  4'b0101, {1'b0, 5'd0, 1'b1, 5'd3, 1'b1, 5'd4}};
    vecs[5] = '{4'b0000, 4'b1111, {5'd1, 5'd2, 5'd3, 5'd4},  4'b0000, {1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0}};

    force_coll = 1'b0;
    err_clr    = 1'b0;
    reset      = 1'b1;
    rf_clear   = 1'b1;
    applyStimulus(4'hF, 4'h0, {5'd4, 5'd3, 5'd2, 5'd1}, '0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("reset ready", req_ready, 0);
    checkOutput("reset rsp_valid", rsp_valid, 0);
    checkOutput("reset rsp_data", rsp_data, 0);
    checkOutput("reset err", err, 0);
    checkOutput("reset rf enables", {rf_wen, rf_ren1, rf_ren2}, 0);
    reset    = 1'b0;
    rf_clear = 1'b0;

    // Unwritten read returns zero one cycle later.
    applyStimulus(4'b0001, 4'b0000, {15'd0, 5'd5}, '0);
    #1 checkOutput("seq1 ready", req_ready, 4'b0001);
    @(negedge clk);
    checkOutput("seq1 rsp_valid", rsp_valid, 4'b0001);
    checkOutput("seq1 rsp_data", rsp_data, 0);

    // Write beats same-address read; deferred read returns new data.
    applyStimulus(4'b0110, 4'b0010, {5'd0, 5'd5, 5'd5, 5'd0}, {32'd0, 16'hBEEF, 16'd0});
    #1 checkOutput("seq2 ready", req_ready, 4'b0010);
    @(negedge clk);
    checkOutput("seq2 rsp_valid", rsp_valid, 0);
    applyStimulus(4'b0100, 4'b0000, {5'd0, 5'd5, 10'd0}, '0);
    #1 checkOutput("seq2 retry ready", req_ready, 4'b0100);
    @(negedge clk);
    checkOutput("seq2 rsp_valid retry", rsp_valid, 4'b0100);
    checkOutput("seq2 rsp_data retry", rsp_data, {16'd0, 16'hBEEF, 32'd0});
    checkOutput("seq2 collision", rf_collision, 0);

    // Single-cycle table from a freshly reset pointer.
    for (int i = 0; i < 6; i++) begin
      doReset(1'b0);
      applyStimulus(vecs[i].valid, vecs[i].we, vecs[i].addr, 64'h4444_3333_2222_1111);
      #1;
      checkOutput($sformatf("vec%0d ready", i), req_ready, vecs[i].exp_ready);
      act_rf = {rf_wen, rf_wen ? rf_wad : 5'd0, rf_ren1, rf_ren1 ? rf_rad1 : 5'd0,
                rf_ren2, rf_ren2 ? rf_rad2 : 5'd0};
      checkOutput($sformatf("vec%0d rf ports", i), act_rf, vecs[i].exp_rf);
      checkOutput($sformatf("vec%0d idle rad", i),
                  (rf_ren1 || rf_rad1 == ~rf_wad) && (rf_ren2 || rf_rad2 == ~rf_wad), 1);
      @(negedge clk);
      applyStimulus('0, '0, '0, '0);
      checkOutput($sformatf("vec%0d rsp_valid", i), rsp_valid,
                  vecs[i].exp_ready & ~vecs[i].we);
    end

    // All writers: one grant per cycle, rotating.
    doReset(1'b0);
    applyStimulus(4'hF, 4'hF, {5'd4, 5'd3, 5'd2, 5'd1}, 64'h0004_0003_0002_0001);
    for (int k = 0; k < 8; k++) begin
      #1 checkOutput($sformatf("rotate %0d", k), req_ready, 4'b0001 << (k % 4));
      @(negedge clk);
    end

    // Two readers of one address, order set by the pointer.
    doReset(1'b0);
    applyStimulus(4'b0010, 4'b0010, {10'd0, 5'd9, 5'd0}, {32'd0, 16'h5A5A, 16'd0});
    #1 checkOutput("same addr write ready", req_ready, 4'b0010);
    @(negedge clk);
    applyStimulus(4'b1001, 4'b0000, {5'd9, 10'd0, 5'd9}, '0);
    #1 checkOutput("same addr first ready", req_ready, 4'b1000);
    @(negedge clk);
    checkOutput("same addr rsp3", rsp_data, {16'h5A5A, 48'd0});
    applyStimulus(4'b0001, 4'b0000, {15'd0, 5'd9}, '0);
    #1 checkOutput("same addr second ready", req_ready, 4'b0001);
    @(negedge clk);
    checkOutput("same addr rsp0", rsp_data, {48'd0, 16'h5A5A});
    checkOutput("same addr collision", rf_collision, 0);

    // ERR entry, in-flight completion, and clear.
    doReset(1'b0);
    applyStimulus(4'hF, 4'h0, {5'd13, 5'd12, 5'd11, 5'd10}, '0);
    force_coll = 1'b1;
    #1 checkOutput("err pre ready", req_ready, 4'b0011);
    @(negedge clk);
    applyStimulus(4'b1100, 4'h0, {5'd13, 5'd12, 5'd11, 5'd10}, '0);
    #1;
    checkOutput("err flag", err, 1);
    checkOutput("err ready", req_ready, 0);
    checkOutput("err enables", {rf_wen, rf_ren1, rf_ren2}, 0);
    checkOutput("err inflight rsp", rsp_valid, 4'b0011);
    force_coll = 1'b0;
    @(negedge clk);
    checkOutput("err hold", err, 1);
    checkOutput("err hold rsp", rsp_valid, 0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checkOutput("err cleared", err, 0);
    #1 checkOutput("err resume ready", req_ready, 4'b1100);
    @(negedge clk);
    checkOutput("err resume rsp", rsp_valid, 4'b1100);

    // Reset while a response is outstanding.
    applyStimulus(4'b0001, 4'b0000, {15'd0, 5'd5}, '0);
    #1 checkOutput("rst read ready", req_ready, 4'b0001);
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(4'b0010, 4'b0000, {10'd0, 5'd6, 5'd0}, '0);
    #1;
    checkOutput("rst inflight rsp", rsp_valid, 4'b0001);
    checkOutput("rst ready gated", req_ready, 0);
    @(negedge clk);
    checkOutput("rst rsp dropped", rsp_valid, 0);
    reset = 1'b0;

    // Randomised traffic against the reference arbiter and a memory shadow.
    doReset(1'b1);
    for (int j = 0; j < 32; j++) mmem[j] = '0;
    pv = '0; pwe = '0; pa = '0; pwd = '0; mptr = 0; exp_rv = '0; exp_rd = '0;
    for (int c = 0; c < 400; c++) begin
      checkOutput("rand rsp_valid", rsp_valid, exp_rv);
      checkOutput("rand rsp_data", rsp_data, exp_rd);
      for (int i = 0; i < N; i++) begin
        if (!pv[i] && $urandom_range(0, 9) < 7) begin
          pv[i]            = 1'b1;
          pwe[i]           = ($urandom_range(0, 2) == 0);
          pa[5*i +: 5]     = 5'($urandom_range(0, 7));
          pwd[16*i +: 16]  = 16'($urandom);
        end
      end
      applyStimulus(pv, pwe, pa, pwd);
      #1;
      g = ref_grant(pv, pwe, pa, mptr, nptr);
      checkOutput("rand ready", req_ready, g);
      exp_rv = '0;
      exp_rd = '0;
      for (int i = 0; i < N; i++) begin
        if (g[i] && !pwe[i]) begin
          exp_rv[i]          = 1'b1;
          exp_rd[16*i +: 16] = mmem[pa[5*i +: 5]];
        end
      end
      for (int i = 0; i < N; i++) begin
        if (g[i] && pwe[i]) mmem[pa[5*i +: 5]] = pwd[16*i +: 16];
      end
      pv   = pv & ~g;
      mptr = nptr;
      @(negedge clk);
    end
    checkOutput("rand collision", rf_collision, 0);
    checkOutput("rand err", err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
